// File: rtl/soc_pio_in_irq.sv
// Avalon-MM input PIO with 2-FF synchronisation, optional per-bit debounce,
// edge capture (write-one-to-clear) and a maskable level interrupt.
// Register map: 0 data (filtered inputs), 1 reserved (reads 0),
//               2 irqmask (R/W), 3 edge_capture (read / W1C).
module soc_pio_in_irq #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] filt_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edge_capture_r;
  logic [31:0]      rd_mux_s;
  logic             wr_en_s;
  logic             unused_s;

  // Only the low WIDTH bits of writedata carry register content.
  assign unused_s = ^writedata;

  // Two-flop synchroniser for the asynchronous external inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= in_port;
      sync2_r <= sync1_r;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      assign filt_s = sync2_r;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      // Counter value at which the Nth consecutive differing cycle is seen.
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0]    cnt_r [WIDTH];
      logic [WIDTH-1:0] filt_r;

      // Per-bit stability counter: accept a new level only after N differing cycles.
      always_ff @(posedge clk) begin
        if (reset) begin
          filt_r <= {WIDTH{1'b0}};
          for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= {CW{1'b0}};
          end
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync2_r[i] == filt_r[i]) begin
              cnt_r[i] <= {CW{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
              filt_r[i] <= sync2_r[i];
              cnt_r[i]  <= {CW{1'b0}};
            end else begin
              cnt_r[i] <= cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
      end

      assign filt_s = filt_r;
    end
  endgenerate

  // Previous filtered value for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= {WIDTH{1'b0}};
    end else begin
      prev_r <= filt_s;
    end
  end

  assign rise_s = filt_s & ~prev_r;
  assign fall_s = ~filt_s & prev_r;

  // Select which edge polarity is captured.
  always_comb begin
    edge_s = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      0:       edge_s = rise_s;
      1:       edge_s = fall_s;
      default: edge_s = rise_s | fall_s;
    endcase
  end

  assign wr_en_s = chipselect & ~write_n;

  // Write-one-to-clear mask from a write to the edge_capture register.
  always_comb begin
    clr_s = {WIDTH{1'b0}};
    if (wr_en_s && (address == 2'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_r <= {WIDTH{1'b0}};
    end else if (wr_en_s && (address == 2'd2)) begin
      irqmask_r <= writedata[WIDTH-1:0];
    end else begin
      irqmask_r <= irqmask_r;
    end
  end

  // Edge capture: a new edge wins over a simultaneous clear of the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture_r <= {WIDTH{1'b0}};
    end else begin
      edge_capture_r <= (edge_capture_r & ~clr_s) | edge_s;
    end
  end

  // Interrupt built from registers only so it cannot glitch.
  assign irq = |(edge_capture_r & irqmask_r);

  // Read multiplexer, zero-extended to the bus width.
  always_comb begin
    rd_mux_s = {32{1'b0}};
    case (address)
      2'd0:    rd_mux_s[WIDTH-1:0] = filt_s;
      2'd1:    rd_mux_s = {32{1'b0}};
      2'd2:    rd_mux_s[WIDTH-1:0] = irqmask_r;
      2'd3:    rd_mux_s[WIDTH-1:0] = edge_capture_r;
      default: rd_mux_s = {32{1'b0}};
    endcase
  end

  // Registered read data, refreshed every cycle regardless of chipselect.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= {32{1'b0}};
    end else begin
      readdata <= rd_mux_s;
    end
  end

endmodule

// File: tb/tb_soc_pio_in_irq.sv
// Scoreboard bench for soc_pio_in_irq: two instances (no-debounce rising-edge,
// and 4-cycle debounce any-edge). Stimulus pushes expectations; a monitor
// compares them against the DUT outputs one clock edge later.
module tb_soc_pio_in_irq;

  typedef struct {
    int          d;
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  logic        clk;
  logic        reset0, reset1;
  logic [1:0]  address0, address1;
  logic        chipselect0, chipselect1;
  logic        write_n0, write_n1;
  logic [31:0] writedata0, writedata1;
  logic [31:0] readdata0, readdata1;
  logic [3:0]  in_port0, in_port1;
  logic        irq0, irq1;

  sb_entry_t   sb_q[$];
  logic        iss;
  logic        pend;
  int          total;
  int          bad;

  soc_pio_in_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset(reset0), .address(address0), .chipselect(chipselect0),
    .write_n(write_n0), .writedata(writedata0), .readdata(readdata0),
    .in_port(in_port0), .irq(irq0)
  );

  soc_pio_in_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut1 (
    .clk(clk), .reset(reset1), .address(address1), .chipselect(chipselect1),
    .write_n(write_n1), .writedata(writedata1), .readdata(readdata1),
    .in_port(in_port1), .irq(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An issued check becomes due after the next rising edge.
  always @(posedge clk) pend <= iss;

  // Monitor: pop and compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (pend) begin
      if (sb_q.size() == 0) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL sb_underflow: check due but no expectation queued");
      end else begin
        sb_entry_t e;
        logic [31:0] act;
        e = sb_q.pop_front();
        if (e.is_irq) act = {31'd0, (e.d == 0) ? irq0 : irq1};
        else          act = (e.d == 0) ? readdata0 : readdata1;
        total = total + 1;
        if (act !== e.exp) begin
          bad = bad + 1;
          $display("FAIL %s (dut%0d): got %h expected %h", e.name, e.d, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
    if (d == 0) begin
      chipselect0 = 1'b1; write_n0 = 1'b0; address0 = a; writedata0 = v;
    end else begin
      chipselect1 = 1'b1; write_n1 = 1'b0; address1 = a; writedata1 = v;
    end
    tick();
    chipselect0 = 1'b0; write_n0 = 1'b1;
    chipselect1 = 1'b0; write_n1 = 1'b1;
  endtask

  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e, input string nm);
    sb_entry_t s;
    if (d == 0) address0 = a;
    else        address1 = a;
    s.d = d; s.is_irq = 1'b0; s.exp = e; s.name = nm;
    sb_q.push_back(s);
    iss = 1'b1;
    tick();
    iss = 1'b0;
  endtask

  task automatic chk_irq(input int d, input logic e, input string nm);
    sb_entry_t s;
    s.d = d; s.is_irq = 1'b1; s.exp = {31'd0, e}; s.name = nm;
    sb_q.push_back(s);
    iss = 1'b1;
    tick();
    iss = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; iss = 1'b0; pend = 1'b0;
    reset0 = 1'b1; reset1 = 1'b1;
    address0 = 2'd0; address1 = 2'd0;
    chipselect0 = 1'b0; chipselect1 = 1'b0;
    write_n0 = 1'b1; write_n1 = 1'b1;
    writedata0 = 32'd0; writedata1 = 32'd0;
    in_port0 = 4'd0; in_port1 = 4'd0;
    tick(); tick();
    reset0 = 1'b0; reset1 = 1'b0;

    // Reset state of both instances.
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 4; a++) rd(d, 2'(a), 32'h0, "reset_rd");
      chk_irq(d, 1'b0, "reset_irq");
    end

    // dut0: 0000 -> 0101 step, readdata changes on the third edge.
    in_port0 = 4'b0101;
    rd(0, 2'd0, 32'h0, "step_lat1");
    rd(0, 2'd0, 32'h0, "step_lat2");
    rd(0, 2'd0, 32'h5, "step_lat3");
    rd(0, 2'd3, 32'h5, "cap_rise");
    chk_irq(0, 1'b0, "irq_masked");
    wr(0, 2'd2, 32'h4);
    chk_irq(0, 1'b1, "irq_unmask");
    wr(0, 2'd3, 32'h4);
    chk_irq(0, 1'b0, "irq_clear");
    rd(0, 2'd3, 32'h1, "cap_after_w1c");
    rd(0, 2'd2, 32'h4, "mask_rd");
    // Writes to addresses 0 and 1 change nothing.
    wr(0, 2'd0, 32'hFFFF_FFFF);
    wr(0, 2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd0, 32'h5, "ro_data");
    rd(0, 2'd1, 32'h0, "addr1_zero");
    rd(0, 2'd2, 32'h4, "ro_mask");
    rd(0, 2'd3, 32'h1, "ro_cap");
    wr(0, 2'd2, 32'hFFFF_FFFF);
    rd(0, 2'd2, 32'hF, "mask_trunc");
    chk_irq(0, 1'b1, "irq_full_mask");

    // dut1: 3-cycle glitch on bit0 must be rejected.
    in_port1 = 4'b0001;
    tick(); tick(); tick();
    in_port1 = 4'b0000;
    repeat (6) tick();
    rd(1, 2'd0, 32'h0, "glitch_filt");
    rd(1, 2'd3, 32'h0, "glitch_cap");
    chk_irq(1, 1'b0, "glitch_irq");

    // Held step: filt at edge 6 (seen by the 7th read), capture one edge later.
    in_port1 = 4'b0001;
    for (int k = 0; k < 7; k++) rd(1, 2'd0, (k == 6) ? 32'h1 : 32'h0, "deb_filt");
    rd(1, 2'd3, 32'h1, "deb_cap");

    // Any-edge capture on bit1 with a W1C between the edges.
    in_port1 = 4'b0011;
    repeat (8) tick();
    rd(1, 2'd3, 32'h3, "any_rise");
    wr(1, 2'd3, 32'h2);
    rd(1, 2'd3, 32'h1, "w1c_bit1");
    in_port1 = 4'b0001;
    repeat (8) tick();
    rd(1, 2'd3, 32'h3, "any_fall");
    wr(1, 2'd3, 32'h2);
    // Clear write lands on the same edge that captures the new rise.
    in_port1 = 4'b0011;
    repeat (6) tick();
    wr(1, 2'd3, 32'h2);
    rd(1, 2'd3, 32'h3, "set_wins");

    // Reset while bit2 is mid-debounce (count 2).
    wr(1, 2'd2, 32'hF);
    chk_irq(1, 1'b1, "irq_pre_reset");
    in_port1 = 4'b0111;
    repeat (4) tick();
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    chk_irq(1, 1'b0, "rst_irq");
    rd(1, 2'd0, 32'h0, "rst_filt");
    rd(1, 2'd2, 32'h0, "rst_mask");
    rd(1, 2'd3, 32'h0, "rst_cap");
    rd(1, 2'd0, 32'h0, "requal_early1");
    rd(1, 2'd0, 32'h0, "requal_early2");
    rd(1, 2'd0, 32'h7, "requal_filt");
    rd(1, 2'd3, 32'h7, "requal_cap");

    tick(); tick();
    if (sb_q.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
